ddr_init_seq: RTL and testbench

DDR SDRAM power-up initialisation sequencer, the stage directly downstream of the clock/reset generator. It runs in the 133 MHz memory domain and starts only after the generator releases reset, that is, once the DCMs are locked and the reset is debounced. It drives the JEDEC DDR power-up command sequence onto the SDRAM command/address bus, then reports `initDone`. Optionally it also generates periodic auto-refresh.

---
 rtl/ddr_init_seq.sv | 247 ++++++++++++++++++++++++
 tb/tb_ddr_init_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ddr_init_seq.sv
// ddr_init_seq
//   DDR SDRAM power-up initialisation sequencer for the 133 MHz memory domain.
//   After reset is released it holds CKE low for INIT_WAIT cycles, then walks the
//   JEDEC power-up command list (PRECHARGE ALL, EMR, MR with DLL reset, PRECHARGE
//   ALL, two AUTO REFRESH, MR) and raises initDone once the DLL has settled.
//
//   Optional feature macro: DDR_AUTO_REFRESH_EN
//     defined   -> periodic refresh requests with a refReq/refAck/refBusy handshake
//     undefined -> refReq = refBusy = 0, refAck ignored, NOP forever after DONE
//
// Ports
//   clk       in   memory clock, rising edge
//   rstN      in   synchronous active-low reset
//   cke       out  SDRAM clock enable
//   csN, rasN, casN, weN  out  SDRAM command
//   ba        out  [1:0]  bank address
//   addr      out  [12:0] SDRAM address
//   initDone  out  power-up sequence complete (sticky until reset)
//   refReq    out  refresh due
//   refAck    in   controller hands the command bus over for refresh
//   refBusy   out  this block owns the command bus for refresh
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WAIT_CKE | CKE low, DESELECT, counting INIT_WAIT
// CKE_NOP  | CKE just raised, one NOP
// PRE1     | first PRECHARGE ALL issued, waiting T_RP
// EMR      | LOAD MODE (extended) issued, waiting T_MRD
// MR_RST   | LOAD MODE with DLL reset issued, waiting T_MRD
// PRE2     | second PRECHARGE ALL issued, waiting T_RP
// REF1     | first AUTO REFRESH issued, waiting T_RFC
// REF2     | second AUTO REFRESH issued, waiting T_RFC
// DLL_WT   | final LOAD MODE issued, waiting DLL_WAIT
// DONE     | initialised, bus idle (NOP)
// RF_PRE   | refresh: PRECHARGE ALL issued, waiting T_RP
// RF_REF   | refresh: AUTO REFRESH issued, waiting T_RFC

module ddr_init_seq #(
  parameter int unsigned INIT_WAIT    = 26600,
  parameter int unsigned T_RP         = 3,
  parameter int unsigned T_MRD        = 2,
  parameter int unsigned T_RFC        = 10,
  parameter int unsigned DLL_WAIT     = 200,
  parameter logic [12:0] MODE_REG     = 13'h021,
  parameter logic [12:0] EXT_MODE     = 13'h000,
  parameter int unsigned REF_INTERVAL = 1040
) (
  input  logic        clk,
  input  logic        rstN,
  output logic        cke,
  output logic        csN,
  output logic        rasN,
  output logic        casN,
  output logic        weN,
  output logic [1:0]  ba,
  output logic [12:0] addr,
  output logic        initDone,
  output logic        refReq,
  input  logic        refAck,
  output logic        refBusy
);

  localparam logic [3:0] WAIT_CKE = 4'd0;
  localparam logic [3:0] CKE_NOP  = 4'd1;
  localparam logic [3:0] PRE1     = 4'd2;
  localparam logic [3:0] EMR      = 4'd3;
  localparam logic [3:0] MR_RST   = 4'd4;
  localparam logic [3:0] PRE2     = 4'd5;
  localparam logic [3:0] REF1     = 4'd6;
  localparam logic [3:0] REF2     = 4'd7;
  localparam logic [3:0] DLL_WT   = 4'd8;
  localparam logic [3:0] DONE     = 4'd9;
`ifdef DDR_AUTO_REFRESH_EN
  localparam logic [3:0] RF_PRE   = 4'd10;
  localparam logic [3:0] RF_REF   = 4'd11;
`endif

  // {csN, rasN, casN, weN}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;

  localparam logic [12:0] ADDR_PRE_ALL = 13'h0400;  // A10 selects all banks
  localparam logic [12:0] ADDR_A8      = 13'h0100;  // DLL reset bit in MR

  // Counter load values: a wait of N cycles loads N-1 on the issue cycle.
  localparam logic [15:0] LD_INIT = 16'(INIT_WAIT - 1);
  localparam logic [15:0] LD_RP   = 16'(T_RP - 1);
  localparam logic [15:0] LD_MRD  = 16'(T_MRD - 1);
  localparam logic [15:0] LD_RFC  = 16'(T_RFC - 1);
  localparam logic [15:0] LD_DLL  = 16'(DLL_WAIT - 1);

  logic [3:0]  state;
  logic [15:0] cnt;
  logic        started;  // first cycle out of reset loads the CKE-low wait
  logic [3:0]  cmdQ;

  assign {csN, rasN, casN, weN} = cmdQ;

`ifdef DDR_AUTO_REFRESH_EN
  localparam logic [15:0] LD_REFI = 16'(REF_INTERVAL - 1);

  logic [15:0] refCnt;
  logic        refPend;
  logic        refExpire;
  logic        ackTake;
  logic        busyEnd;

  always_comb begin
    refExpire = initDone && (refCnt == '0);
    ackTake   = refReq && !refBusy && refAck;
    busyEnd   = (state == RF_REF) && (cnt == '0);
  end
`else
  logic unusedRefAck;
  assign unusedRefAck = refAck & (REF_INTERVAL != 0);
  assign refReq  = 1'b0;
  assign refBusy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state    <= WAIT_CKE;
      cnt      <= '0;
      started  <= 1'b0;
      cke      <= 1'b0;
      cmdQ     <= CMD_DESEL;
      ba       <= 2'b00;
      addr     <= '0;
      initDone <= 1'b0;
`ifdef DDR_AUTO_REFRESH_EN
      refCnt   <= '0;
      refPend  <= 1'b0;
      refReq   <= 1'b0;
      refBusy  <= 1'b0;
`endif
    end else begin
      cmdQ <= CMD_NOP;
      ba   <= 2'b00;
      addr <= '0;
      if (cnt != '0) cnt <= cnt - 16'd1;

      case (state)
        WAIT_CKE: begin
          cmdQ <= CMD_DESEL;
          if (!started) begin
            started <= 1'b1;
            cnt     <= LD_INIT;
          end else if (cnt == '0) begin
            cke   <= 1'b1;
            cmdQ  <= CMD_NOP;
            state <= CKE_NOP;
          end
        end
        CKE_NOP: begin
          cmdQ  <= CMD_PRE;
          addr  <= ADDR_PRE_ALL;
          cnt   <= LD_RP;
          state <= PRE1;
        end
        PRE1: if (cnt == '0) begin
          cmdQ  <= CMD_LMR;
          ba    <= 2'b01;
          addr  <= EXT_MODE;
          cnt   <= LD_MRD;
          state <= EMR;
        end
        EMR: if (cnt == '0) begin
          cmdQ  <= CMD_LMR;
          addr  <= MODE_REG | ADDR_A8;
          cnt   <= LD_MRD;
          state <= MR_RST;
        end
        MR_RST: if (cnt == '0) begin
          cmdQ  <= CMD_PRE;
          addr  <= ADDR_PRE_ALL;
          cnt   <= LD_RP;
          state <= PRE2;
        end
        PRE2: if (cnt == '0) begin
          cmdQ  <= CMD_REF;
          cnt   <= LD_RFC;
          state <= REF1;
        end
        REF1: if (cnt == '0) begin
          cmdQ  <= CMD_REF;
          cnt   <= LD_RFC;
          state <= REF2;
        end
        REF2: if (cnt == '0) begin
          cmdQ  <= CMD_LMR;
          addr  <= MODE_REG & ~ADDR_A8;
          cnt   <= LD_DLL;
          state <= DLL_WT;
        end
        DLL_WT: if (cnt == '0) begin
          initDone <= 1'b1;
          state    <= DONE;
`ifdef DDR_AUTO_REFRESH_EN
          refCnt   <= LD_REFI;
`endif
        end
`ifdef DDR_AUTO_REFRESH_EN
        DONE: if (ackTake) begin
          refBusy <= 1'b1;
          cmdQ    <= CMD_PRE;
          addr    <= ADDR_PRE_ALL;
          cnt     <= LD_RP;
          state   <= RF_PRE;
        end
        RF_PRE: if (cnt == '0) begin
          cmdQ  <= CMD_REF;
          cnt   <= LD_RFC;
          state <= RF_REF;
        end
        RF_REF: if (cnt == '0) begin
          refBusy <= 1'b0;
          state   <= DONE;
        end
`else
        DONE: ;
`endif
        default: state <= WAIT_CKE;
      endcase

`ifdef DDR_AUTO_REFRESH_EN
      // Interval timer free-runs once initialised, independent of the handshake.
      if (initDone) refCnt <= (refCnt == '0) ? LD_REFI : refCnt - 16'd1;

      // One pending slot absorbs an expiry while a request is outstanding or a
      // refresh is in progress; it is replayed as refBusy drops.
      if (busyEnd) begin
        refReq  <= refPend | refExpire;
        refPend <= refPend & refExpire;
      end else if (refReq || refBusy) begin
        if (ackTake) refReq <= 1'b0;
        if (refExpire) refPend <= 1'b1;
      end else if (refExpire) begin
        refReq <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ddr_init_seq.sv
module tb_ddr_init_seq;

  logic        clk;
  logic        rstN;
  logic        refAck;
  logic        cke, csN, rasN, casN, weN;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic        initDone, refReq, refBusy;
  logic [22:0] v1;

  int nChecks = 0;
  int nFail   = 0;

  localparam logic [22:0] RST_VEC = {1'b0, 4'b1111, 2'b00, 13'h0000, 1'b0, 1'b0, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ddr_init_seq #(
    .INIT_WAIT(10), .T_RP(3), .T_MRD(2), .T_RFC(10), .DLL_WAIT(200),
    .MODE_REG(13'h021), .EXT_MODE(13'h000), .REF_INTERVAL(50)
  ) dut (
    .clk(clk), .rstN(rstN), .cke(cke), .csN(csN), .rasN(rasN), .casN(casN),
    .weN(weN), .ba(ba), .addr(addr), .initDone(initDone), .refReq(refReq),
    .refAck(refAck), .refBusy(refBusy)
  );

  assign v1 = {cke, csN, rasN, casN, weN, ba, addr, initDone, refReq, refBusy};

`ifdef DDR_AUTO_REFRESH_EN
  logic        refAck2;
  logic        cke2, csN2, rasN2, casN2, weN2;
  logic [1:0]  ba2;
  logic [12:0] addr2;
  logic        initDone2, refReq2, refBusy2;
  logic [22:0] v2;

  ddr_init_seq #(
    .INIT_WAIT(10), .T_RP(3), .T_MRD(2), .T_RFC(10), .DLL_WAIT(200),
    .MODE_REG(13'h021), .EXT_MODE(13'h000), .REF_INTERVAL(8)
  ) dut2 (
    .clk(clk), .rstN(rstN), .cke(cke2), .csN(csN2), .rasN(rasN2), .casN(casN2),
    .weN(weN2), .ba(ba2), .addr(addr2), .initDone(initDone2), .refReq(refReq2),
    .refAck(refAck2), .refBusy(refBusy2)
  );

  assign v2 = {cke2, csN2, rasN2, casN2, weN2, ba2, addr2, initDone2, refReq2, refBusy2};
`endif

  // Expected bus for the power-up sequence, cycle c counted from reset release.
  function automatic logic [22:0] expBase(int c);
    logic        ckeE;
    logic [3:0]  cmdE;
    logic [1:0]  baE;
    logic [12:0] addrE;
    logic        doneE;
    ckeE  = (c >= 10);
    cmdE  = (c < 10) ? 4'b1111 : 4'b0111;
    baE   = 2'b00;
    addrE = 13'h0000;
    doneE = (c >= 241);
    case (c)
      11, 18: begin cmdE = 4'b0010; addrE = 13'h0400; end
      14:     begin cmdE = 4'b0000; baE = 2'b01; addrE = 13'h0000; end
      16:     begin cmdE = 4'b0000; addrE = 13'h0121; end
      21, 31: cmdE = 4'b0001;
      41:     begin cmdE = 4'b0000; addrE = 13'h0021; end
      default: ;
    endcase
    return {ckeE, cmdE, baE, addrE, doneE, 1'b0, 1'b0};
  endfunction

`ifdef DDR_AUTO_REFRESH_EN
  // REF_INTERVAL=50, refAck sampled at cycle 296.
  function automatic logic [22:0] expDut1(int c);
    logic [22:0] e;
    e = expBase(c);
    e[1] = (c >= 291 && c < 296) || (c >= 341);
    e[0] = (c >= 296 && c < 309);
    if (c == 296) begin e[21:18] = 4'b0010; e[15:3] = 13'h0400; end
    if (c == 299) e[21:18] = 4'b0001;
    return e;
  endfunction

  // REF_INTERVAL=8, refAck withheld until cycle 269; pending request replays at 282.
  function automatic logic [22:0] expDut2(int c);
    logic [22:0] e;
    e = expBase(c);
    e[1] = (c >= 249 && c < 269) || (c >= 282);
    e[0] = (c >= 269 && c < 282);
    if (c == 269) begin e[21:18] = 4'b0010; e[15:3] = 13'h0400; end
    if (c == 272) e[21:18] = 4'b0001;
    return e;
  endfunction
`endif

  task automatic check(input string tag, input int c, input logic [22:0] obs,
                       input logic [22:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int lastCycle;
`ifdef DDR_AUTO_REFRESH_EN
    int     rises;
    logic   prevReq2;
    refAck2   = 1'b0;
    lastCycle = 360;
    rises     = 0;
    prevReq2  = 1'b0;
`else
    lastCycle = 241 + 2000;
`endif
    rstN   = 1'b0;
    refAck = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      check("resetVals", i, v1, RST_VEC);
    end

    rstN = 1'b1;
    for (int c = 0; c < 17; c++) begin
      tick();
      check("seqBeforeReset", c, v1, expBase(c));
    end

    rstN = 1'b0;
    for (int c = 17; c < 20; c++) begin
      tick();
      check("midReset", c, v1, RST_VEC);
`ifdef DDR_AUTO_REFRESH_EN
      check("midReset2", c, v2, RST_VEC);
`endif
    end

    rstN = 1'b1;
    for (int c = 0; c <= lastCycle; c++) begin
`ifdef DDR_AUTO_REFRESH_EN
      refAck  = (c >= 296 && c <= 300);
      refAck2 = (c == 269);
`else
      refAck  = (c >= 242) ? c[0] : 1'b0;
`endif
      tick();
`ifdef DDR_AUTO_REFRESH_EN
      check("refDut1", c, v1, expDut1(c));
      check("refDut2", c, v2, expDut2(c));
      if (c >= 270 && c <= 300 && refReq2 && !prevReq2) rises++;
      prevReq2 = refReq2;
`else
      check("seq", c, v1, expBase(c));
`endif
    end

`ifdef DDR_AUTO_REFRESH_EN
    check("pendingRises", 300, 23'(rises), 23'd1);
`endif

    refAck = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
